// File: rtl/xbox_arb_pkg.sv
// Shared types and constants for the TCM dmem arbiter.
package xbox_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic [31:0] DEAD_DATA  = 32'hDEADBEEF;
  // default ADDR_W for the dmem word address
  localparam int          DEF_ADDR_W = 19;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner picker: first requesting index at/after ptr (or from 0 when fixed).
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       fixed,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] base;
  logic [IW-1:0] j;

  assign base = fixed ? '0 : ptr;

  // Scan from the far end so the nearest requester to base is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(base) + k) % NUM_REQ);
      if (req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/xbox_dmem_arb.sv
// N-way arbiter in front of the TCM dmem port: one transaction in flight, timeout abort, sticky errors.
module xbox_dmem_arb
  import xbox_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic [NUM_REQ-1:0]          req_rvalid,
  input  logic [NUM_REQ-1:0]          req_wvalid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]       req_wdata,
  input  logic [NUM_REQ*4-1:0]        req_wbe,
  output logic [NUM_REQ-1:0]          req_rready,
  output logic [NUM_REQ-1:0]          req_wready,
  output logic [31:0]                 req_rdata,

  output logic                        xbox_dmem_rvalid,
  output logic                        xbox_dmem_wvalid,
  output logic [ADDR_W-1:0]           xbox_dmem_addr,
  output logic [31:0]                 xbox_dmem_wdata,
  output logic [3:0]                  xbox_dmem_wbe,
  input  logic                        xbox_dmem_rready,
  input  logic                        xbox_dmem_wready,
  input  logic [31:0]                 xbox_dmem_rdata,

  input  logic                        prio_mode,
  input  logic                        err_clr,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
  output logic                        timeout_err,
  output logic                        proto_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] gnt_q, rr_ptr_q, gnt_nxt;
  logic [CW-1:0] cnt_q;
  logic          init_q;
  logic          terr_q, perr_q;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          active, grant;
  logic          g_rv, g_wv, g_any;
  logic          g_done, g_abort, g_drop, g_dual;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_rvalid | req_wvalid),
    .ptr   (rr_ptr_q),
    .fixed (prio_mode),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Reset gates the live datapath immediately so no ready leaks out of an abandoned transaction.
  assign active  = (state_q == BUSY) && !rst;
  assign g_rv    = req_rvalid[gnt_q];
  assign g_wv    = req_wvalid[gnt_q];
  assign g_any   = g_rv | g_wv;
  assign g_drop  = active && !g_any;
  assign g_done  = active && (g_wv ? xbox_dmem_wready : (g_rv && xbox_dmem_rready));
  assign g_abort = active && g_any && !g_done && (cnt_q == CW'(TIMEOUT));
  assign g_dual  = active && g_rv && g_wv;
  // init_q holds off the first grant for one edge after reset releases.
  assign grant   = (state_q == IDLE) && !init_q && pick_valid;
  assign gnt_nxt = (int'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = BUSY;
      BUSY:    if (g_drop || g_done || g_abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_rready       = '0;
    req_wready       = '0;
    req_rdata        = '0;
    xbox_dmem_rvalid = 1'b0;
    xbox_dmem_wvalid = 1'b0;
    xbox_dmem_addr   = '0;
    xbox_dmem_wdata  = '0;
    xbox_dmem_wbe    = '0;
    if (active && g_any) begin
      xbox_dmem_addr  = req_addr[int'(gnt_q)*ADDR_W +: ADDR_W];
      xbox_dmem_wdata = req_wdata[int'(gnt_q)*32 +: 32];
      xbox_dmem_wbe   = req_wbe[int'(gnt_q)*4 +: 4];
      req_rdata       = xbox_dmem_rdata;
      // A simultaneous read+write request is served as a write only.
      if (g_wv) begin
        xbox_dmem_wvalid  = 1'b1;
        req_wready[gnt_q] = xbox_dmem_wready | g_abort;
      end else begin
        xbox_dmem_rvalid  = 1'b1;
        req_rready[gnt_q] = xbox_dmem_rready | g_abort;
        if (g_abort) req_rdata = DEAD_DATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      init_q   <= 1'b1;
      terr_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      init_q <= 1'b0;
      if (grant) begin
        gnt_q <= pick_idx;
        cnt_q <= '0;
      end else if (active && !(g_done || g_abort || g_drop)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (g_done || g_abort) rr_ptr_q <= gnt_nxt;
      // Error set beats a same-cycle clear.
      if (g_abort)               terr_q <= 1'b1;
      else if (err_clr)          terr_q <= 1'b0;
      if (g_dual || g_drop)      perr_q <= 1'b1;
      else if (err_clr)          perr_q <= 1'b0;
    end
  end

  assign busy        = active;
  assign gnt_id      = gnt_q;
  assign timeout_err = terr_q;
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_xbox_dmem_arb.sv
// Directed scenario bench for xbox_dmem_arb with hand-computed expectations.
module tb_xbox_dmem_arb;
  import xbox_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 19;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_rvalid, req_wvalid, req_rready, req_wready;
  logic [N*AW-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N*4-1:0]  req_wbe;
  logic [31:0]     req_rdata;
  logic            xbox_dmem_rvalid, xbox_dmem_wvalid;
  logic [AW-1:0]   xbox_dmem_addr;
  logic [31:0]     xbox_dmem_wdata;
  logic [3:0]      xbox_dmem_wbe;
  logic            xbox_dmem_rready, xbox_dmem_wready;
  logic [31:0]     xbox_dmem_rdata;
  logic            prio_mode, err_clr, busy, timeout_err, proto_err;
  logic [1:0]      gnt_id;

  int checks = 0;
  int errors = 0;

  xbox_dmem_arb #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req_rvalid(req_rvalid), .req_wvalid(req_wvalid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wbe(req_wbe), .req_rready(req_rready),
    .req_wready(req_wready), .req_rdata(req_rdata),
    .xbox_dmem_rvalid(xbox_dmem_rvalid), .xbox_dmem_wvalid(xbox_dmem_wvalid),
    .xbox_dmem_addr(xbox_dmem_addr), .xbox_dmem_wdata(xbox_dmem_wdata),
    .xbox_dmem_wbe(xbox_dmem_wbe), .xbox_dmem_rready(xbox_dmem_rready),
    .xbox_dmem_wready(xbox_dmem_wready), .xbox_dmem_rdata(xbox_dmem_rdata),
    .prio_mode(prio_mode), .err_clr(err_clr), .busy(busy), .gnt_id(gnt_id),
    .timeout_err(timeout_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    req_rvalid = '0; req_wvalid = '0; req_addr = '0; req_wdata = '0; req_wbe = '0;
    xbox_dmem_rready = 1'b0; xbox_dmem_wready = 1'b0; xbox_dmem_rdata = '0;
    prio_mode = 1'b0; err_clr = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; clear_inputs(); step();
    rst = 1'b0; step(); step();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_inputs(); step(); step(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt got %0d want 0", gnt_id); end
    checks++; if ({timeout_err, proto_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b want 00", {timeout_err, proto_err}); end
    checks++; if ({req_rready, req_wready, xbox_dmem_rvalid, xbox_dmem_wvalid} !== '0) begin errors++;
      $display("FAIL reset_handshake got %b want 0", {req_rready, req_wready, xbox_dmem_rvalid, xbox_dmem_wvalid}); end
    req_wvalid = 4'b1000; step(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy got %b want 0", busy); end
    req_wvalid = '0; rst = 1'b0; step(); step();
  endtask

  task automatic test_single_read();
    int busyc = 0, pulses = 0;
    req_rvalid[2] = 1'b1; req_addr[2*AW +: AW] = 19'h100; #1;
    checks++; if (xbox_dmem_rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid got %b want 0", xbox_dmem_rvalid); end
    for (int c = 0; c < 5; c++) begin
      step();
      xbox_dmem_rready = (c == 3);
      xbox_dmem_rdata  = (c == 3) ? 32'h12345678 : 32'h0;
      if (c == 4) req_rvalid = '0;
      #1;
      busyc += int'(busy); pulses += int'(req_rready[2]);
      if (c == 0) begin
        checks++; if (gnt_id !== 2'd2) begin errors++; $display("FAIL rd_gnt got %0d want 2", gnt_id); end
        checks++; if (xbox_dmem_addr !== 19'h100 || xbox_dmem_rvalid !== 1'b1) begin errors++;
          $display("FAIL rd_addr got %h/%b want 100/1", xbox_dmem_addr, xbox_dmem_rvalid); end
      end
      if (c == 3) begin
        checks++; if (req_rready !== 4'b0100) begin errors++; $display("FAIL rd_rready got %b want 0100", req_rready); end
        checks++; if (req_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_rdata got %h want 12345678", req_rdata); end
      end
    end
    xbox_dmem_rready = 1'b0;
    checks++; if (busyc != 4) begin errors++; $display("FAIL rd_busy_cycles got %0d want 4", busyc); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL rd_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_rr_writes();
    logic [1:0] g;
    prio_mode = 1'b0;
    for (int i = 0; i < N; i++) req_wdata[i*32 +: 32] = 32'hA000_0000 + i;
    req_wvalid = '1; xbox_dmem_wready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); #1;
      if (i % 2 == 0) begin
        g = 2'((i / 2) % 4);
        checks++; if (busy !== 1'b1 || gnt_id !== g) begin errors++;
          $display("FAIL rr_grant step %0d got busy=%b gnt=%0d want busy=1 gnt=%0d", i, busy, gnt_id, g); end
        checks++; if (req_wready !== (4'b0001 << g) || xbox_dmem_wdata !== 32'hA000_0000 + 32'(g)) begin errors++;
          $display("FAIL rr_wready step %0d got %b/%h want %b", i, req_wready, xbox_dmem_wdata, 4'b0001 << g); end
      end else begin
        checks++; if (busy !== 1'b0 || req_wready !== 4'b0000) begin errors++;
          $display("FAIL rr_bubble step %0d got busy=%b wready=%b want 0/0000", i, busy, req_wready); end
      end
    end
    req_wvalid = '0; xbox_dmem_wready = 1'b0; step();
  endtask

  task automatic test_fixed_prio();
    int starved = 0;
    prio_mode = 1'b1; req_wvalid = 4'b1010; xbox_dmem_wready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      if (busy === 1'b1 && gnt_id === 2'd3) starved++;
      if (i % 2 == 0) begin
        checks++; if (busy !== 1'b1 || gnt_id !== 2'd1 || req_wready !== 4'b0010) begin errors++;
          $display("FAIL prio_grant step %0d got busy=%b gnt=%0d wready=%b want 1/1/0010", i, busy, gnt_id, req_wready); end
      end
    end
    checks++; if (starved != 0) begin errors++; $display("FAIL prio_starve got %0d want 0", starved); end
    req_wvalid = '0; xbox_dmem_wready = 1'b0; prio_mode = 1'b0; step();
  endtask

  task automatic test_timeout();
    int early = 0;
    req_rvalid[0] = 1'b1; xbox_dmem_rdata = 32'h0BAD_0BAD;
    for (int c = 0; c < 256; c++) begin
      step(); #1;
      if (c < 255) early += int'(req_rready[0]);
      else begin
        checks++; if (busy !== 1'b1 || req_rready !== 4'b0001) begin errors++;
          $display("FAIL to_pulse got busy=%b rready=%b want 1/0001", busy, req_rready); end
        checks++; if (req_rdata !== DEAD_DATA) begin errors++; $display("FAIL to_rdata got %h want deadbeef", req_rdata); end
      end
    end
    step(); req_rvalid = '0; #1;
    checks++; if (early != 0) begin errors++; $display("FAIL to_early got %0d pulses want 0", early); end
    checks++; if (timeout_err !== 1'b1 || proto_err !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL to_err got terr=%b perr=%b busy=%b want 1/0/0", timeout_err, proto_err, busy); end
    step(); step(); #1;
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", timeout_err); end
    err_clr = 1'b1; step(); err_clr = 1'b0; #1;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clr got %b want 0", timeout_err); end
  endtask

  task automatic test_timeout_race();
    req_rvalid[0] = 1'b1;
    for (int c = 0; c < 256; c++) begin
      step();
      xbox_dmem_rready = (c == 255); xbox_dmem_rdata = 32'hCAFE_F00D;
      #1;
      if (c == 255) begin
        checks++; if (req_rready !== 4'b0001 || req_rdata !== 32'hCAFE_F00D) begin errors++;
          $display("FAIL race_data got %b/%h want 0001/cafef00d", req_rready, req_rdata); end
      end
    end
    step(); req_rvalid = '0; xbox_dmem_rready = 1'b0; #1;
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL race_err got terr=%b busy=%b want 0/0", timeout_err, busy); end
  endtask

  task automatic test_dual_valid();
    req_rvalid[1] = 1'b1; req_wvalid[1] = 1'b1;
    req_wdata[32 +: 32] = 32'h55AA_55AA; req_wbe[7:4] = 4'b0011;
    step(); xbox_dmem_wready = 1'b1; #1;
    checks++; if (gnt_id !== 2'd1 || xbox_dmem_wvalid !== 1'b1 || xbox_dmem_rvalid !== 1'b0) begin errors++;
      $display("FAIL dual_valids got gnt=%0d w=%b r=%b want 1/1/0", gnt_id, xbox_dmem_wvalid, xbox_dmem_rvalid); end
    checks++; if (xbox_dmem_wdata !== 32'h55AA_55AA || xbox_dmem_wbe !== 4'b0011) begin errors++;
      $display("FAIL dual_data got %h/%b want 55aa55aa/0011", xbox_dmem_wdata, xbox_dmem_wbe); end
    checks++; if (req_wready !== 4'b0010 || req_rready !== 4'b0000) begin errors++;
      $display("FAIL dual_ready got w=%b r=%b want 0010/0000", req_wready, req_rready); end
    step(); req_rvalid = '0; req_wvalid = '0; xbox_dmem_wready = 1'b0; #1;
    checks++; if (proto_err !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL dual_perr got perr=%b busy=%b want 1/0", proto_err, busy); end
    err_clr = 1'b1; step(); err_clr = 1'b0; #1;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_clr got %b want 0", proto_err); end
    // clear held high across a fresh protocol error
    err_clr = 1'b1; req_rvalid[1] = 1'b1; req_wvalid[1] = 1'b1;
    step(); xbox_dmem_wready = 1'b1;
    step(); req_rvalid = '0; req_wvalid = '0; xbox_dmem_wready = 1'b0; #1;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL set_wins got %b want 1", proto_err); end
    step(); err_clr = 1'b0; #1;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL set_wins_clr got %b want 0", proto_err); end
  endtask

  task automatic test_reset_mid_busy();
    int wpulse = 0;
    req_wvalid = 4'b0100;
    step(); #1; wpulse += int'(|req_wready);
    step(); #1; wpulse += int'(|req_wready);
    req_wvalid = 4'b0101; #1;
    checks++; if (busy !== 1'b1 || gnt_id !== 2'd2) begin errors++;
      $display("FAIL mid_pre got busy=%b gnt=%0d want 1/2", busy, gnt_id); end
    rst = 1'b1; step(); #1; wpulse += int'(|req_wready);
    checks++; if (busy !== 1'b0 || gnt_id !== 2'd0 || xbox_dmem_wvalid !== 1'b0 || req_wready !== 4'b0000) begin errors++;
      $display("FAIL mid_rst got busy=%b gnt=%0d wv=%b wr=%b want 0/0/0/0000", busy, gnt_id, xbox_dmem_wvalid, req_wready); end
    rst = 1'b0; step(); #1; wpulse += int'(|req_wready);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_holdoff got busy=%b want 0", busy); end
    step(); #1; wpulse += int'(|req_wready);
    checks++; if (busy !== 1'b1 || gnt_id !== 2'd0) begin errors++;
      $display("FAIL mid_regrant got busy=%b gnt=%0d want 1/0", busy, gnt_id); end
    checks++; if (wpulse != 0) begin errors++; $display("FAIL mid_nopulse got %0d want 0", wpulse); end
    req_wvalid = '0; rst = 1'b1; step(); rst = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    apply_reset();
    test_rr_writes();
    test_fixed_prio();
    test_timeout();
    test_timeout_race();
    test_dual_valid();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
